// File: rtl/third_fsm_pkg.sv
// Shared definitions for the 1-0-1-1 serial sequence detector: state encoding,
// state width and the reference pattern used by benches and scoreboards.
package third_fsm_pkg;

  localparam int unsigned STATE_W = 3;
  localparam logic [3:0]  PATTERN = 4'b1011;

  typedef enum logic [STATE_W-1:0] {
    S0 = 3'b000,
    S1 = 3'b001,
    S2 = 3'b010,
    S3 = 3'b011,
    S4 = 3'b100
  } state_e;

endpackage

// File: rtl/third_fsm.sv
// Moore detector for the overlapping serial pattern 1-0-1-1 (oldest bit first);
// Output is high for one cycle while the FSM sits in the match state S4.
module third_fsm
  import third_fsm_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic x,
  output logic Output
);

  state_e state_q, state_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S0;
    else      state_q <= state_d;
  end

  // Unused codes 101/110/111 fall into the default and recover to S0.
  always_comb begin
    state_d = S0;
    case (state_q)
      S0:      state_d = x ? S1 : S0;
      S1:      state_d = x ? S1 : S2;
      S2:      state_d = x ? S3 : S0;
      S3:      state_d = x ? S4 : S2;
      S4:      state_d = x ? S1 : S2;
      default: state_d = S0;
    endcase
  end

  assign Output = (state_q == S4);

endmodule

// File: tb/tb_third_fsm.sv
// Directed-vector and randomized check of third_fsm against a 4-bit history
// reference model that compares the last four sampled bits with PATTERN.
module tb_third_fsm;
  import third_fsm_pkg::*;

  logic clk;
  logic rst;
  logic x;
  logic Output;

  int checks;
  int failures;

  third_fsm dut (
    .clk    (clk),
    .rst    (rst),
    .x      (x),
    .Output (Output)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic rst_v;
    logic x_v;
    logic exp_v;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: Output=%b expected=%b at t=%0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs on the falling edge, sample Output 1 time unit after the rising edge.
  task automatic step(input logic r, input logic b, output logic out);
    @(negedge clk);
    rst = r;
    x   = b;
    @(posedge clk);
    #1;
    out = Output;
  endtask

  task automatic add(input logic r, input logic b, input logic e);
    vec_t v;
    v.rst_v = r;
    v.x_v   = b;
    v.exp_v = e;
    vecs.push_back(v);
  endtask

  initial begin
    logic       got;
    logic       prev_out;
    logic [3:0] hist;
    logic       exp_o;
    string      nm;

    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    x        = 1'b0;
    #1;
    check("reset_initial", Output, 1'b0);

    // Reset held while the pattern is presented.
    add(0,1,0); add(0,0,0); add(0,1,0); add(0,1,0);
    // Basic detection, then drain to S0.
    add(1,1,0); add(1,0,0); add(1,1,0); add(1,1,1); add(1,0,0); add(1,0,0);
    // Overlap 1011011 -> pulses after 4th and 7th edge.
    add(1,1,0); add(1,0,0); add(1,1,0); add(1,1,1); add(1,0,0); add(1,1,0); add(1,1,1);
    add(1,0,0); add(1,0,0);
    // Near miss 11111, then 011 proves the FSM was parked in S1.
    add(1,1,0); add(1,1,0); add(1,1,0); add(1,1,0); add(1,1,0);
    add(1,0,0); add(1,1,0); add(1,1,1); add(1,0,0); add(1,0,0);
    // Near miss 10011.
    add(1,1,0); add(1,0,0); add(1,0,0); add(1,1,0); add(1,1,0); add(1,0,0); add(1,0,0);
    // Reset mid-sequence discards "101"; the following 1 must not pulse.
    add(1,1,0); add(1,0,0); add(1,1,0); add(0,1,0); add(0,1,0); add(1,1,0);
    add(1,0,0); add(1,1,0); add(1,1,1); add(1,0,0); add(1,0,0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst_v, vecs[i].x_v, got);
      nm = $sformatf("vec%0d", i);
      check(nm, got, vecs[i].exp_v);
    end

    // Async reset between edges while in S4: Output must drop without a clock edge.
    step(1, 1, got); step(1, 0, got); step(1, 1, got); step(1, 1, got);
    check("s4_before_async_rst", got, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_immediate", Output, 1'b0);
    @(posedge clk);
    #1;
    check("async_rst_held", Output, 1'b0);
    // Release between edges changes nothing; then 1,1 must not pulse (no prefix).
    #2;
    rst = 1'b1;
    #1;
    check("rst_release_quiet", Output, 1'b0);
    step(1, 1, got); check("after_release_1", got, 1'b0);
    step(1, 1, got); check("after_release_2", got, 1'b0);
    step(1, 0, got); step(1, 0, got);

    // Random run against the history model with occasional resets.
    hist     = 4'b0000;
    prev_out = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      logic r, b;
      r = ($urandom_range(0, 39) != 0);
      b = 1'($urandom_range(0, 1));
      if (!r) hist = 4'b0000;
      else    hist = {hist[2:0], b};
      exp_o = (hist == PATTERN);
      step(r, b, got);
      nm = $sformatf("rand%0d", n);
      check(nm, got, exp_o);
      if (prev_out && got) begin
        checks++;
        failures++;
        $display("FAIL double_pulse: Output=1 expected=0 on two consecutive cycles at t=%0t", $time);
      end
      prev_out = got;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
